// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   fetch_state_e    : fetch FSM states (IDLE, REQ, DROP)
//   INST_BYTES       : instruction size in bytes (fetch PC stride)
//   DEFAULT_RESET_PC : default first fetch address
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    REQ  = 2'd1,  // request outstanding, data will be kept
    DROP = 2'd2   // request outstanding, data will be discarded (redirected)
  } fetch_state_e;

  localparam int INST_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a registered head word.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_data (ignored when full unless popping too)
//   push_data   : word to write
//   pop         : drop the head word (ignored when empty)
//   flush       : empty the FIFO; wins over push and pop
//   full, empty : occupancy flags
//   count       : number of stored words
//   head        : registered copy of the oldest word (RESET_HEAD after reset)
module fetch_fifo #(
  parameter int               WIDTH      = 64,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_HEAD = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_inc;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] head_next;
  logic             do_push;
  logic             do_pop;

  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign do_pop     = pop & ~empty;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign do_push    = push & (~full | do_pop);
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;

  // Storage array carries no reset; only pointers and head are initialised.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // The head register tracks whichever word becomes oldest after this edge:
  // the next stored entry, or the incoming word when it is the only one left.
  always_comb begin
    head_next = head_reg;
    if (do_pop) begin
      if (count_reg > CW'(1)) begin
        head_next = mem_reg[rd_ptr_inc];
      end else if (do_push) begin
        head_next = push_data;
      end
    end else if (empty && do_push) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= RESET_HEAD;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      head_reg  <= head_next;
    end
  end

  assign count = count_reg;
  assign head  = head_reg;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues one outstanding
// instruction-memory read at a time, buffers returned words in a prefetch
// FIFO and presents the oldest one to the controller.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   write_pc               : controller consume strobe (acts only with W_IR_valid)
//   pc_load, pc_load_val   : redirect pulse and target (low 2 bits ignored)
//   W_IR_valid             : head instruction available
//   ir_data, ir_pc         : head instruction and its address
//   imem_req, imem_addr    : memory read request, held stable until ack
//   imem_rdata, imem_ack   : read data and one-cycle completion
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              W_IR_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack
);

  localparam int                CW         = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

  fetch_state_e               state_reg;
  fetch_state_e               state_next;
  logic [ADDR_W-1:0]          fetch_pc_reg;
  logic [ADDR_W-1:0]          fetch_pc_next;
  logic [ADDR_W-1:0]          drop_addr_reg;
  logic                       take;
  logic                       pop;
  logic                       push;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CW-1:0]              fifo_count;
  logic [CW-1:0]              count_after_push;
  logic [DATA_W+ADDR_W-1:0]   head;

  // A redirect discards both the same-cycle consume and the same-cycle ack.
  assign take = write_pc & W_IR_valid;
  assign pop  = take & ~pc_load;
  assign push = (state_reg == REQ) & imem_ack & ~pc_load;

  // In REQ the outstanding request already owns a slot, so after its push
  // the occupancy is count + 1 - pop; stay in REQ only if a slot is still free.
  assign count_after_push = fifo_count + CW'(1) - CW'(pop);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    unique case (state_reg)
      IDLE: begin
        if (pc_load || !fifo_full) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (pc_load) begin
          // If the ack lands with the redirect nothing is left in flight,
          // so the redirected fetch can be issued straight away.
          state_next = imem_ack ? REQ : DROP;
        end else if (imem_ack) begin
          fetch_pc_next = fetch_pc_reg + ADDR_W'(INST_BYTES);
          if (count_after_push == CW'(DEPTH)) begin
            state_next = IDLE;
          end
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
    if (pc_load) begin
      fetch_pc_next = pc_load_val & ALIGN_MASK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      fetch_pc_reg  <= RESET_PC;
      drop_addr_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      // fetch_pc moves to the redirect target, so remember the address of
      // the abandoned request to keep imem_addr stable until its ack.
      if (state_reg == REQ && state_next == DROP) begin
        drop_addr_reg <= fetch_pc_reg;
      end
    end
  end

  assign imem_req  = (state_reg != IDLE);
  assign imem_addr = (state_reg == DROP) ? drop_addr_reg : fetch_pc_reg;

  fetch_fifo #(
    .WIDTH      (DATA_W + ADDR_W),
    .DEPTH      (DEPTH),
    .RESET_HEAD ({{DATA_W{1'b0}}, RESET_PC})
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_rdata, imem_addr}),
    .pop       (pop),
    .flush     (pc_load),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

  assign W_IR_valid = ~fifo_empty;
  assign ir_data    = head[DATA_W+ADDR_W-1:ADDR_W];
  assign ir_pc      = head[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: a directed cycle table, a reset-mid-request
// sequence, and randomized runs against a queue-based reference model.
module tb_inst_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_pc = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = '0;
  logic        W_IR_valid;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write_pc    (write_pc),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .W_IR_valid  (W_IR_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack)
  );

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check1({tag, "_valid"}, W_IR_valid, 1'b0);
    check1({tag, "_req"}, imem_req, 1'b0);
    check32({tag, "_addr"}, imem_addr, 32'h0);
    check32({tag, "_ir_pc"}, ir_pc, 32'h0);
    check32({tag, "_ir_data"}, ir_data, 32'h0);
  endtask

  // Hold reset for two cycles and release it on a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    write_pc = 1'b0;
    pc_load = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: FIFO contents as a queue of addresses plus the address
  // the next kept fetch must use.
  logic [31:0] q[$];
  logic [31:0] exp_fetch;
  logic [31:0] req_addr;
  bit          drop_pend;
  bit          in_req;
  bit          prev_lt;
  int          wait_cnt;
  int          cur_lat;
  int          ntake;

  // lat < 0 picks a random 0..3 cycle latency per request.
  task automatic run_random(input int cycles, input int lat, input int take_pct, input int load_pct);
    q.delete();
    exp_fetch = 32'h0;
    drop_pend = 0;
    in_req    = 0;
    prev_lt   = 0;
    wait_cnt  = 0;
    cur_lat   = 0;
    ntake     = 0;
    for (int c = 0; c < cycles; c++) begin
      #1;
      check1("valid", W_IR_valid, q.size() > 0);
      if (q.size() > 0) begin
        check32("ir_pc", ir_pc, q[0]);
        check32("ir_data", ir_data, mem_data(q[0]));
      end
      if (q.size() == DEPTH) begin
        check1("req_when_full", imem_req, 1'b0);
      end else if (prev_lt) begin
        check1("req_when_space", imem_req, 1'b1);
      end
      prev_lt = (q.size() < DEPTH);

      // Memory: ack after cur_lat waiting cycles, random data otherwise.
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (imem_req) begin
        if (!in_req) begin
          in_req   = 1;
          req_addr = imem_addr;
          wait_cnt = 0;
          cur_lat  = (lat < 0) ? int'($urandom_range(3, 0)) : lat;
        end else begin
          check32("addr_stable", imem_addr, req_addr);
        end
        if (wait_cnt >= cur_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_data(req_addr);
          in_req     = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        in_req = 0;
      end

      write_pc = ($urandom_range(99, 0) < take_pct);
      pc_load  = ($urandom_range(99, 0) < load_pct);
      if ($urandom_range(3, 0) == 0) pc_load_val = 32'hFFFF_FFF0 + $urandom_range(15, 0);
      else pc_load_val = $urandom;

      if (pc_load) begin
        q.delete();
        drop_pend = imem_req && !imem_ack;
        exp_fetch = pc_load_val & 32'hFFFF_FFFC;
      end else begin
        if (write_pc && q.size() > 0) begin
          void'(q.pop_front());
          ntake++;
        end
        if (imem_ack) begin
          if (drop_pend) begin
            drop_pend = 0;
          end else begin
            check32("fetch_addr", req_addr, exp_fetch);
            q.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            check1("no_overfill", q.size() <= DEPTH, 1'b1);
          end
        end
      end
      @(negedge clk);
    end
    write_pc = 1'b0;
    pc_load  = 1'b0;
    imem_ack = 1'b0;
  endtask

  // One row per cycle: outputs expected at the start of the cycle, then the
  // inputs driven for the following rising edge.
  typedef struct {
    logic        ev;
    logic [31:0] epc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        wr;
    logic        ack;
    logic        ld;
    logic [31:0] ldv;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // fill with 1-cycle ack latency, then a redirect while 0x8 is in flight,
    // then redirect+take+ack together to a misaligned target near the wrap.
    vecs[0]  = '{N, 32'h0,        N, 32'h0,        N, N, N, 32'h0};
    vecs[1]  = '{N, 32'h0,        Y, 32'h0,        Y, N, N, 32'h0};
    vecs[2]  = '{N, 32'h0,        Y, 32'h0,        Y, Y, N, 32'h0};
    vecs[3]  = '{Y, 32'h0,        Y, 32'h4,        N, N, N, 32'h0};
    vecs[4]  = '{Y, 32'h0,        Y, 32'h4,        N, Y, N, 32'h0};
    vecs[5]  = '{Y, 32'h0,        N, 32'h8,        N, N, N, 32'h0};
    vecs[6]  = '{Y, 32'h0,        N, 32'h8,        Y, N, N, 32'h0};
    vecs[7]  = '{Y, 32'h4,        N, 32'h8,        N, N, N, 32'h0};
    vecs[8]  = '{Y, 32'h4,        Y, 32'h8,        N, N, Y, 32'h100};
    vecs[9]  = '{N, 32'h0,        Y, 32'h8,        Y, Y, N, 32'h0};
    vecs[10] = '{N, 32'h0,        Y, 32'h100,      Y, Y, N, 32'h0};
    vecs[11] = '{Y, 32'h100,      Y, 32'h104,      Y, Y, Y, 32'hFFFF_FFFE};
    vecs[12] = '{N, 32'h0,        Y, 32'hFFFF_FFFC, N, Y, N, 32'h0};
    vecs[13] = '{Y, 32'hFFFF_FFFC, Y, 32'h0,       Y, Y, N, 32'h0};
    vecs[14] = '{Y, 32'h0,        Y, 32'h4,        N, N, N, 32'h0};
    vecs[15] = '{Y, 32'h0,        Y, 32'h4,        N, N, N, 32'h0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      #1;
      check1($sformatf("vec%0d_valid", i), W_IR_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        check32($sformatf("vec%0d_ir_pc", i), ir_pc, vecs[i].epc);
        check32($sformatf("vec%0d_ir_data", i), ir_data, mem_data(vecs[i].epc));
      end
      check1($sformatf("vec%0d_req", i), imem_req, vecs[i].ereq);
      check32($sformatf("vec%0d_addr", i), imem_addr, vecs[i].eaddr);
      write_pc    = vecs[i].wr;
      imem_ack    = vecs[i].ack;
      imem_rdata  = vecs[i].ack ? mem_data(imem_addr) : 32'hDEAD_BEEF;
      pc_load     = vecs[i].ld;
      pc_load_val = vecs[i].ldv;
      @(negedge clk);
    end

    // Reset mid-request: outputs must return to reset values without a clock.
    #1;
    check1("pre_rst_req", imem_req, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Continuous take with zero-wait memory: one instruction per cycle
    // once the first word has arrived (first valid two cycles after reset).
    do_reset();
    run_random(60, 0, 100, 0);
    check1("throughput", ntake >= 58, 1'b1);

    do_reset();
    run_random(40, 1, 0, 0);
    do_reset();
    run_random(80, 3, 100, 0);
    do_reset();
    run_random(2000, -1, 50, 8);
    do_reset();
    run_random(1500, 0, 30, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
